// File: rtl/demux_scan_if.sv
// Control, serial data and status bundle between a scan master and demux_scan_ctrl.
interface demux_scan_if #(
  parameter int unsigned DW = 8
);
  logic          start;
  logic          stop;
  logic          cont;
  logic [7:0]    en_mask;
  logic [DW-1:0] dwell;
  logic          i;
  logic [2:0]    sel;
  logic [7:0]    o;
  logic          busy;
  logic          slot_start;
  logic          done;

  modport master (
    output start, stop, cont, en_mask, dwell, i,
    input  sel, o, busy, slot_start, done
  );

  modport slave (
    input  start, stop, cont, en_mask, dwell, i,
    output sel, o, busy, slot_start, done
  );
endinterface

// File: rtl/demux_scan_ctrl.sv
// Scans a 1-to-8 registered demux across the enabled channels, holding each
// channel for a latched dwell period; single-pass or continuous under start/stop.
module demux_scan_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  logic [7:0]    mask_l;
  logic [DW-1:0] dwell_l;
  logic          cont_l;
  logic [DW-1:0] cnt_q;
  logic          stop_flag;
  logic [2:0]    sel_q;
  logic [7:0]    o_q;
  logic          busy_q;
  logic          slot_start_q;
  logic          done_q;

  logic [2:0]    nxt_sel_c;
  logic          wrap_c;
  logic          slot_end_c;
  logic          finish_c;
  logic [7:0]    route_c;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Next enabled channel strictly above sel; wrap to the lowest when none remains.
  always_comb begin
    nxt_sel_c = lowest_set(mask_l);
    wrap_c    = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      if (mask_l[k] && (k > int'(sel_q))) begin
        nxt_sel_c = 3'(k);
        wrap_c    = 1'b0;
      end
    end
  end

  assign slot_end_c = (cnt_q == (dwell_l - DW'(1)));
  assign finish_c   = slot_end_c && (stop_flag || bus.stop || (wrap_c && !cont_l));
  assign route_c    = (8'(1) << sel_q) & {8{bus.i}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_l       <= '0;
      dwell_l      <= '0;
      cont_l       <= 1'b0;
      cnt_q        <= '0;
      stop_flag    <= 1'b0;
      sel_q        <= '0;
      o_q          <= '0;
      busy_q       <= 1'b0;
      slot_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      slot_start_q <= 1'b0;
      done_q       <= 1'b0;
      o_q          <= '0;
      case (state)
        IDLE: begin
          // STOP has priority over START; an empty mask is not a scan.
          if (bus.start && !bus.stop && (bus.en_mask != '0)) begin
            mask_l       <= bus.en_mask;
            dwell_l      <= (bus.dwell == '0) ? DW'(1) : bus.dwell;
            cont_l       <= bus.cont;
            sel_q        <= lowest_set(bus.en_mask);
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            slot_start_q <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) stop_flag <= 1'b1;
          if (finish_c) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FINISH;
          end else if (slot_end_c) begin
            cnt_q        <= '0;
            o_q          <= route_c;
            sel_q        <= nxt_sel_c;
            slot_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DW'(1);
            o_q   <= route_c;
          end
        end
        FINISH: begin
          stop_flag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.o          = o_q;
  assign bus.busy       = busy_q;
  assign bus.slot_start = slot_start_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl: per-cycle vector tables plus hand-built corner sequences.
module tb_demux_scan_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  demux_scan_if #(.DW(8)) bus ();

  demux_scan_ctrl #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       i;
    logic [2:0] sel;
    logic [7:0] o;
    logic       busy;
    logic       ss;
    logic       done;
  } vec_t;

  vec_t sp [14];
  vec_t rt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int idx, input vec_t v);
    chk($sformatf("%s[%0d].sel", tag, idx), 32'(bus.sel), 32'(v.sel));
    chk($sformatf("%s[%0d].o", tag, idx), 32'(bus.o), 32'(v.o));
    chk($sformatf("%s[%0d].busy", tag, idx), 32'(bus.busy), 32'(v.busy));
    chk($sformatf("%s[%0d].slot_start", tag, idx), 32'(bus.slot_start), 32'(v.ss));
    chk($sformatf("%s[%0d].done", tag, idx), 32'(bus.done), 32'(v.done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] mask, input logic [7:0] dw, input logic c);
    bus.en_mask = mask;
    bus.dwell   = dw;
    bus.cont    = c;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start = 0; bus.stop = 0; bus.cont = 0;
    bus.en_mask = '0; bus.dwell = '0; bus.i = 0;

    // Single pass, mask a5, dwell 3: {i, sel, o, busy, slot_start, done}
    sp[0]  = '{1'b1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    sp[1]  = '{1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    sp[2]  = '{1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    sp[3]  = '{1'b1, 3'd2, 8'h01, 1'b1, 1'b1, 1'b0};
    sp[4]  = '{1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
    sp[5]  = '{1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
    sp[6]  = '{1'b1, 3'd5, 8'h04, 1'b1, 1'b1, 1'b0};
    sp[7]  = '{1'b1, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
    sp[8]  = '{1'b1, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
    sp[9]  = '{1'b1, 3'd7, 8'h20, 1'b1, 1'b1, 1'b0};
    sp[10] = '{1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0};
    sp[11] = '{1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0};
    sp[12] = '{1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1};
    sp[13] = '{1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0};

    // Routing, mask 10, dwell 4, continuous; i is driven after each check
    rt[0] = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 1'b0};
    rt[1] = '{1'b0, 3'd4, 8'h10, 1'b1, 1'b0, 1'b0};
    rt[2] = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0};
    rt[3] = '{1'b1, 3'd4, 8'h10, 1'b1, 1'b0, 1'b0};
    rt[4] = '{1'b0, 3'd4, 8'h10, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    #23;
    chk("reset.sel", 32'(bus.sel), 0);
    chk("reset.o", 32'(bus.o), 0);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    rst_n = 1'b1;
    tick();

    // Single pass
    bus.i = 1'b1;
    launch(8'b1010_0101, 8'd3, 1'b0);
    for (int c = 0; c < 14; c++) begin
      chk_vec("single", c, sp[c]);
      if (c < 13) tick();
    end

    // Dwell 0 treated as 1, mask 81
    launch(8'h81, 8'd0, 1'b0);
    chk("d0.sel0", 32'(bus.sel), 0);
    chk("d0.ss0", 32'(bus.slot_start), 1);
    tick();
    chk("d0.sel7", 32'(bus.sel), 7);
    chk("d0.ss7", 32'(bus.slot_start), 1);
    chk("d0.o", 32'(bus.o), 32'h01);
    tick();
    chk("d0.done", 32'(bus.done), 1);
    chk("d0.busy", 32'(bus.busy), 0);
    chk("d0.o_fin", 32'(bus.o), 0);
    tick();
    chk("d0.done_clr", 32'(bus.done), 0);

    // Continuous 06 dwell 2 with STOP mid-slot
    launch(8'h06, 8'd2, 1'b1);
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("cont[%0d].sel", c), 32'(bus.sel), ((c / 2) % 2 == 0) ? 1 : 2);
      chk($sformatf("cont[%0d].done", c), 32'(bus.done), 0);
      chk($sformatf("cont[%0d].busy", c), 32'(bus.busy), 1);
      if (c < 8) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop.busy_hold", 32'(bus.busy), 1);
    chk("stop.done_early", 32'(bus.done), 0);
    tick();
    chk("stop.done", 32'(bus.done), 1);
    chk("stop.busy", 32'(bus.busy), 0);
    chk("stop.sel", 32'(bus.sel), 1);
    tick();

    // START with empty mask, then START+STOP together
    launch(8'h00, 8'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("zero.busy", 32'(bus.busy), 0);
      chk("zero.done", 32'(bus.done), 0);
      tick();
    end
    bus.stop = 1'b1;
    launch(8'h0f, 8'd2, 1'b0);
    bus.stop = 1'b0;
    chk("startstop.busy", 32'(bus.busy), 0);
    chk("startstop.ss", 32'(bus.slot_start), 0);
    tick();
    chk("startstop.busy2", 32'(bus.busy), 0);

    // Data routing through O[4]
    bus.i = 1'b1;
    launch(8'h10, 8'd4, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk_vec("route", c, rt[c]);
      bus.i = rt[c].i;
      if (c < 4) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("route.o_i0", 32'(bus.o), 0);
    chk("route.busy", 32'(bus.busy), 1);
    tick();
    tick();
    chk("route.not_done", 32'(bus.done), 0);
    tick();
    chk("route.done", 32'(bus.done), 1);
    chk("route.o_fin", 32'(bus.o), 0);
    tick();

    // Reset mid-RUN at sel 5
    bus.i = 1'b1;
    launch(8'h20, 8'd5, 1'b1);
    tick();
    chk("rstrun.sel", 32'(bus.sel), 5);
    chk("rstrun.o", 32'(bus.o), 32'h20);
    #1 rst_n = 1'b0;
    #1;
    chk("rstrun.o0", 32'(bus.o), 0);
    chk("rstrun.sel0", 32'(bus.sel), 0);
    chk("rstrun.busy0", 32'(bus.busy), 0);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rstrun.no_done", 32'(bus.done), 0);
      chk("rstrun.idle", 32'(bus.busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
